// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants for the multi-cycle MIPS controller.
// Holds opcode/func codes, ALU operation encodings, FSM state codes and the
// select encodings for the datapath muxes (reg_dst, mem_to_reg, alusrc_a/b, pc_src).
package mips_ctrl_pkg;

   // FSM state codes
   typedef logic [3:0] state_t;
   localparam state_t S_FETCH     = 4'd0;
   localparam state_t S_DECODE    = 4'd1;
   localparam state_t S_MEM_ADDR  = 4'd2;
   localparam state_t S_MEM_READ  = 4'd3;
   localparam state_t S_MEM_WB    = 4'd4;
   localparam state_t S_MEM_WRITE = 4'd5;
   localparam state_t S_R_EXEC    = 4'd6;
   localparam state_t S_R_WB      = 4'd7;
   localparam state_t S_I_EXEC    = 4'd8;
   localparam state_t S_I_WB      = 4'd9;
   localparam state_t S_BRANCH    = 4'd10;
   localparam state_t S_JUMP      = 4'd11;
   localparam state_t S_JR        = 4'd12;
   localparam state_t S_HALT      = 4'd13;
   localparam state_t S_ILLEGAL   = 4'd14;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;

   // ALU operations
   typedef logic [3:0] alu_op_t;
   localparam alu_op_t ALU_ADD = 4'd0;
   localparam alu_op_t ALU_SUB = 4'd1;
   localparam alu_op_t ALU_AND = 4'd2;
   localparam alu_op_t ALU_OR  = 4'd3;
   localparam alu_op_t ALU_XOR = 4'd4;
   localparam alu_op_t ALU_SLL = 4'd5;
   localparam alu_op_t ALU_SRL = 4'd6;
   localparam alu_op_t ALU_SRA = 4'd7;
   localparam alu_op_t ALU_LUI = 4'd8;

   // Datapath mux selects
   typedef logic [1:0] sel_t;
   localparam sel_t REG_DST_RT   = 2'd0;
   localparam sel_t REG_DST_RD   = 2'd1;
   localparam sel_t REG_DST_RA   = 2'd2;
   localparam sel_t M2R_ALUOUT   = 2'd0;
   localparam sel_t M2R_MDR      = 2'd1;
   localparam sel_t M2R_PC       = 2'd2;
   localparam sel_t SRCA_PC      = 2'd0;
   localparam sel_t SRCA_RS      = 2'd1;
   localparam sel_t SRCA_SHAMT   = 2'd2;
   localparam sel_t SRCB_B       = 2'd0;
   localparam sel_t SRCB_FOUR    = 2'd1;
   localparam sel_t SRCB_IMM     = 2'd2;
   localparam sel_t SRCB_IMM_SH2 = 2'd3;
   localparam sel_t PCSRC_ALU    = 2'd0;
   localparam sel_t PCSRC_ALUOUT = 2'd1;
   localparam sel_t PCSRC_JUMP   = 2'd2;
   localparam sel_t PCSRC_RS     = 2'd3;

   // Shifts take their A operand from the shamt field instead of rs.
   function automatic logic is_shift_fn(input logic [5:0] fn);
      return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
   endfunction

   // R-type functions that go through R_EXEC/R_WB (jr is handled separately).
   function automatic logic is_r_alu_fn(input logic [5:0] fn);
      return is_shift_fn(fn) || (fn == FN_ADD) || (fn == FN_SUB) ||
             (fn == FN_AND) || (fn == FN_OR) || (fn == FN_XOR);
   endfunction

endpackage

// File: rtl/alu_func_decode.sv
// alu_func_decode: combinational op/func -> ALU operation map, shared by R_EXEC and I_EXEC.
// Latency: purely combinational. Backpressure: none.
// Ports: op, func (instruction fields) in; alu_ctr (ALUCTR_W, upper bits zero) out.
module alu_func_decode
   import mips_ctrl_pkg::*;
#(
   parameter int ALUCTR_W = 4
) (
   input  logic [5:0]          op,
   input  logic [5:0]          func,
   output logic [ALUCTR_W-1:0] alu_ctr
);

   alu_op_t code;

   always_comb begin
      code = ALU_ADD;
      if (op == OP_RTYPE) begin
         case (func)
            FN_ADD:  code = ALU_ADD;
            FN_SUB:  code = ALU_SUB;
            FN_AND:  code = ALU_AND;
            FN_OR:   code = ALU_OR;
            FN_XOR:  code = ALU_XOR;
            FN_SLL:  code = ALU_SLL;
            FN_SRL:  code = ALU_SRL;
            FN_SRA:  code = ALU_SRA;
            default: code = ALU_ADD;
         endcase
      end else begin
         case (op)
            OP_ADDI: code = ALU_ADD;
            OP_ANDI: code = ALU_AND;
            OP_ORI:  code = ALU_OR;
            OP_XORI: code = ALU_XOR;
            OP_LUI:  code = ALU_LUI;
            default: code = ALU_ADD;
         endcase
      end
   end

   assign alu_ctr = ALUCTR_W'(code);

endmodule

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: multi-cycle MIPS controller sequencing FETCH/DECODE/EXEC/MEM/WB.
// Latency (zero-wait memory): lw 5, sw/R/I 4, beq/j/jal/jr 3 cycles per instruction.
// Backpressure: FETCH/MEM_READ/MEM_WRITE stall on mem_ready; MEM_TIMEOUT waits -> HALT + bus_err.
// Ports: clk, rst (sync, active-high); op/func from IR; zero (ALU flag, used by the datapath
//   together with pc_wr_cond); mem_ready; datapath strobes, mux selects, alu_ctr;
//   sticky bus_err/illegal; ret_cnt retired-instruction counter.
// Option: define MULTI_CYCLE_CONTROL_UNIT_ILLEGAL_TRAP_EN to trap undecodable instructions
//   into ILLEGAL (illegal=1); otherwise they retire as NOPs and illegal stays 0.
module multi_cycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int ALUCTR_W    = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int RET_CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           op,
   input  logic [5:0]           func,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 pc_wr,
   output logic                 pc_wr_cond,
   output logic                 ir_wr,
   output logic                 reg_wr,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic                 i_or_d,
   output logic                 ext_op,
   output logic [1:0]           reg_dst,
   output logic [1:0]           mem_to_reg,
   output logic [1:0]           alusrc_a,
   output logic [1:0]           alusrc_b,
   output logic [1:0]           pc_src,
   output logic [ALUCTR_W-1:0]  alu_ctr,
   output logic                 bus_err,
   output logic                 illegal,
   output logic [RET_CNT_W-1:0] ret_cnt
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   wait_cnt, wait_nxt;
   logic               wait_en, wait_last, timeout, retire, bad_instr;
   logic [ALUCTR_W-1:0] dec_alu;

   // The branch decision (pc_wr_cond & zero) is made in the datapath; the
   // controller only carries the flag through.
   logic unused_zero;
   assign unused_zero = zero;

   alu_func_decode #(.ALUCTR_W(ALUCTR_W)) u_alu_dec (
      .op      (op),
      .func    (func),
      .alu_ctr (dec_alu)
   );

   // The wait that would bring the count up to MEM_TIMEOUT is the last one;
   // mem_ready in that same cycle still completes the access.
   assign wait_last = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

   // ---------------- next-state ----------------
   always_comb begin
      state_nxt = state;
      wait_en   = 1'b0;
      timeout   = 1'b0;
      retire    = 1'b0;
      bad_instr = 1'b0;
      case (state)
         S_FETCH: begin
            wait_en = 1'b1;
            if (mem_ready)      state_nxt = S_DECODE;
            else if (wait_last) begin state_nxt = S_HALT; timeout = 1'b1; end
         end
         S_DECODE: begin
            case (op)
               OP_RTYPE: begin
                  if (is_r_alu_fn(func))  state_nxt = S_R_EXEC;
                  else if (func == FN_JR) state_nxt = S_JR;
                  else                    bad_instr = 1'b1;
               end
               OP_LW, OP_SW:                             state_nxt = S_MEM_ADDR;
               OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_nxt = S_I_EXEC;
               OP_BEQ:                                   state_nxt = S_BRANCH;
               OP_J, OP_JAL:                             state_nxt = S_JUMP;
               default:                                  bad_instr = 1'b1;
            endcase
            if (bad_instr) begin
`ifdef MULTI_CYCLE_CONTROL_UNIT_ILLEGAL_TRAP_EN
               state_nxt = S_ILLEGAL;
`else
               state_nxt = S_FETCH;
               retire    = 1'b1;
`endif
            end
         end
         S_MEM_ADDR:  state_nxt = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ: begin
            wait_en = 1'b1;
            if (mem_ready)      state_nxt = S_MEM_WB;
            else if (wait_last) begin state_nxt = S_HALT; timeout = 1'b1; end
         end
         S_MEM_WRITE: begin
            wait_en = 1'b1;
            if (mem_ready)      begin state_nxt = S_FETCH; retire = 1'b1; end
            else if (wait_last) begin state_nxt = S_HALT; timeout = 1'b1; end
         end
         S_R_EXEC:    state_nxt = S_R_WB;
         S_I_EXEC:    state_nxt = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         S_HALT, S_ILLEGAL: state_nxt = state;
         default:           state_nxt = S_FETCH;   // unused encoding: recover
      endcase
   end

   // Counter clears on completion, on timeout and whenever not waiting.
   assign wait_nxt = (wait_en && !mem_ready && !timeout) ? wait_cnt + CNT_W'(1) : '0;

   // ---------------- state ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         bus_err  <= 1'b0;
         ret_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (timeout) bus_err <= 1'b1;
         if (retire)  ret_cnt <= ret_cnt + RET_CNT_W'(1);
      end
   end

`ifdef MULTI_CYCLE_CONTROL_UNIT_ILLEGAL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clk) begin
      if (rst)                                illegal_q <= 1'b0;
      else if (state == S_DECODE && bad_instr) illegal_q <= 1'b1;
   end
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   // ---------------- outputs ----------------
   // Moore decode of state; FETCH's ir_wr/pc_wr follow mem_ready. Everything
   // is forced idle while rst is high, whatever state the FSM is in.
   always_comb begin
      pc_wr      = 1'b0;
      pc_wr_cond = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      i_or_d     = 1'b0;
      ext_op     = 1'b0;
      reg_dst    = REG_DST_RT;
      mem_to_reg = M2R_ALUOUT;
      alusrc_a   = SRCA_PC;
      alusrc_b   = SRCB_B;
      pc_src     = PCSRC_ALU;
      alu_ctr    = ALUCTR_W'(ALU_ADD);
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_rd   = 1'b1;
               alusrc_b = SRCB_FOUR;
               ir_wr    = mem_ready;
               pc_wr    = mem_ready;
            end
            S_DECODE:    alusrc_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
               alusrc_a = SRCA_RS;
               alusrc_b = SRCB_IMM;
               ext_op   = 1'b1;
            end
            S_MEM_READ: begin
               mem_rd = 1'b1;
               i_or_d = 1'b1;
            end
            S_MEM_WB: begin
               reg_wr     = 1'b1;
               mem_to_reg = M2R_MDR;
            end
            S_MEM_WRITE: begin
               mem_wr = 1'b1;
               i_or_d = 1'b1;
            end
            S_R_EXEC: begin
               alusrc_a = is_shift_fn(func) ? SRCA_SHAMT : SRCA_RS;
               alu_ctr  = dec_alu;
            end
            S_R_WB: begin
               reg_wr  = 1'b1;
               reg_dst = REG_DST_RD;
            end
            S_I_EXEC: begin
               alusrc_a = SRCA_RS;
               alusrc_b = SRCB_IMM;
               ext_op   = (op == OP_ADDI);
               alu_ctr  = dec_alu;
            end
            S_I_WB:      reg_wr = 1'b1;
            S_BRANCH: begin
               alusrc_a   = SRCA_RS;
               alu_ctr    = ALUCTR_W'(ALU_SUB);
               pc_wr_cond = 1'b1;
               pc_src     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
               pc_wr  = 1'b1;
               pc_src = PCSRC_JUMP;
               if (op == OP_JAL) begin
                  reg_wr     = 1'b1;
                  reg_dst    = REG_DST_RA;
                  mem_to_reg = M2R_PC;
               end
            end
            S_JR: begin
               pc_wr  = 1'b1;
               pc_src = PCSRC_RS;
            end
            default: ;   // HALT / ILLEGAL: everything idle
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: per-cycle expected control words are pushed
// to a scoreboard as stimulus is driven and popped/compared at the falling edge.
module tb_multi_cycle_control_unit;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op, func;
   logic        zero, mem_ready;
   logic        pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_rd, mem_wr, i_or_d, ext_op;
   logic [1:0]  reg_dst, mem_to_reg, alusrc_a, alusrc_b, pc_src;
   logic [3:0]  alu_ctr;
   logic        bus_err, illegal;
   logic [31:0] ret_cnt;

   always #5 clk = ~clk;

   multi_cycle_control_unit #(.ALUCTR_W(4), .MEM_TIMEOUT(TMO), .RET_CNT_W(32)) dut (
      .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
      .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .ir_wr(ir_wr), .reg_wr(reg_wr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .i_or_d(i_or_d), .ext_op(ext_op),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alusrc_a(alusrc_a),
      .alusrc_b(alusrc_b), .pc_src(pc_src), .alu_ctr(alu_ctr),
      .bus_err(bus_err), .illegal(illegal), .ret_cnt(ret_cnt)
   );

   typedef struct packed {
      logic pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_rd, mem_wr, i_or_d, ext_op;
      logic [1:0] reg_dst, mem_to_reg, alusrc_a, alusrc_b, pc_src;
      logic [3:0] alu_ctr;
      logic bus_err, illegal;
   } ctl_t;

   typedef struct packed {
      logic [7:0] ph;
      ctl_t       v;
   } exp_t;

   localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_MADDR = 3, P_MRD = 4, P_MWB = 5,
                  P_MWR = 6, P_REX = 7, P_RWB = 8, P_IEX = 9, P_IWB = 10, P_BR = 11,
                  P_JMP = 12, P_JR = 13;

   exp_t        sb[$];
   exp_t        mon_e;
   ctl_t        mon_o;
   int          n_chk = 0, n_bad = 0;
   logic        exp_bus_err = 1'b0, exp_illegal = 1'b0;
   logic [31:0] exp_ret = 32'd0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic string ph_name(input logic [7:0] p);
      case (int'(p))
         P_IDLE: return "idle";    P_FETCH: return "fetch"; P_DEC: return "decode";
         P_MADDR: return "mem_addr"; P_MRD: return "mem_read"; P_MWB: return "mem_wb";
         P_MWR: return "mem_write"; P_REX: return "r_exec"; P_RWB: return "r_wb";
         P_IEX: return "i_exec";   P_IWB: return "i_wb";   P_BR: return "branch";
         P_JMP: return "jump";     P_JR: return "jr";
         default: return "unknown";
      endcase
   endfunction

   function automatic logic [3:0] ref_alu_r(input logic [5:0] f);
      case (f)
         6'h20: return 4'd0; 6'h22: return 4'd1; 6'h24: return 4'd2; 6'h25: return 4'd3;
         6'h26: return 4'd4; 6'h00: return 4'd5; 6'h02: return 4'd6; 6'h03: return 4'd7;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] ref_alu_i(input logic [5:0] o);
      case (o)
         6'h0C: return 4'd2; 6'h0D: return 4'd3; 6'h0E: return 4'd4; 6'h0F: return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   function automatic ctl_t expect_ctl(input int ph, input logic rdy);
      ctl_t c;
      c = '0;
      case (ph)
         P_FETCH: begin c.mem_rd = 1; c.alusrc_b = 2'd1; c.ir_wr = rdy; c.pc_wr = rdy; end
         P_DEC:   c.alusrc_b = 2'd3;
         P_MADDR: begin c.alusrc_a = 2'd1; c.alusrc_b = 2'd2; c.ext_op = 1; end
         P_MRD:   begin c.mem_rd = 1; c.i_or_d = 1; end
         P_MWB:   begin c.reg_wr = 1; c.mem_to_reg = 2'd1; end
         P_MWR:   begin c.mem_wr = 1; c.i_or_d = 1; end
         P_REX:   begin
            c.alusrc_a = (func == 6'h00 || func == 6'h02 || func == 6'h03) ? 2'd2 : 2'd1;
            c.alu_ctr  = ref_alu_r(func);
         end
         P_RWB:   begin c.reg_wr = 1; c.reg_dst = 2'd1; end
         P_IEX:   begin
            c.alusrc_a = 2'd1; c.alusrc_b = 2'd2;
            c.ext_op = (op == 6'h08); c.alu_ctr = ref_alu_i(op);
         end
         P_IWB:   c.reg_wr = 1;
         P_BR:    begin c.alusrc_a = 2'd1; c.alu_ctr = 4'd1; c.pc_wr_cond = 1; c.pc_src = 2'd1; end
         P_JMP:   begin
            c.pc_wr = 1; c.pc_src = 2'd2;
            if (op == 6'h03) begin c.reg_wr = 1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; end
         end
         P_JR:    begin c.pc_wr = 1; c.pc_src = 2'd3; end
         default: ;
      endcase
      c.bus_err = exp_bus_err;
      c.illegal = exp_illegal;
      return c;
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock cycle: drive mem_ready, queue the control word expected this cycle.
   task automatic cyc(input int ph, input logic rdy);
      exp_t e;
      mem_ready = rdy;
      e.ph = 8'(ph);
      e.v  = expect_ctl(ph, rdy);
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         mon_o = {pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_rd, mem_wr, i_or_d, ext_op,
                  reg_dst, mem_to_reg, alusrc_a, alusrc_b, pc_src, alu_ctr, bus_err, illegal};
         chk(ph_name(mon_e.ph), 64'(mon_o), 64'(mon_e.v));
      end
   end

   task automatic reset_dut();
      rst = 1'b1;
      cyc(P_IDLE, 1'b1);            // rst high: strobes gated, sticky flags not yet cleared
      exp_bus_err = 1'b0;
      exp_illegal = 1'b0;
      cyc(P_IDLE, 1'b1);
      rst = 1'b0;
      exp_ret = 32'd0;
      chk("ret_cnt_rst", 64'(ret_cnt), 64'(exp_ret));
   endtask

   // fw: fetch wait cycles; mw: wait cycles in MEM_READ/MEM_WRITE.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
      logic bad = 1'b0;
      op = o; func = f;
      zero = (o == 6'h04) ? 1'b1 : rnd();
      repeat (fw) cyc(P_FETCH, 1'b0);
      cyc(P_FETCH, 1'b1);
      cyc(P_DEC, rnd());
      case (o)
         6'h00: begin
            if (f == 6'h08) cyc(P_JR, rnd());
            else if (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03}) begin
               cyc(P_REX, rnd()); cyc(P_RWB, rnd());
            end else bad = 1'b1;
         end
         6'h23: begin
            cyc(P_MADDR, rnd());
            repeat (mw) cyc(P_MRD, 1'b0);
            cyc(P_MRD, 1'b1);
            cyc(P_MWB, rnd());
         end
         6'h2B: begin
            cyc(P_MADDR, rnd());
            repeat (mw) cyc(P_MWR, 1'b0);
            cyc(P_MWR, 1'b1);
         end
         6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin cyc(P_IEX, rnd()); cyc(P_IWB, rnd()); end
         6'h04:        cyc(P_BR, rnd());
         6'h02, 6'h03: cyc(P_JMP, rnd());
         default:      bad = 1'b1;
      endcase
`ifdef MULTI_CYCLE_CONTROL_UNIT_ILLEGAL_TRAP_EN
      if (bad) begin
         exp_illegal = 1'b1;
         repeat (3) cyc(P_IDLE, rnd());
      end else exp_ret++;
`else
      exp_ret++;    // undecodable instructions retire as NOPs
`endif
      chk("ret_cnt", 64'(ret_cnt), 64'(exp_ret));
   endtask

   logic [5:0] r_fn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03};
   logic [5:0] i_op [5] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; op = 6'h00; func = 6'h20; zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      reset_dut();

      foreach (r_fn[i]) run_instr(6'h00, r_fn[i], 0, 0);
      run_instr(6'h23, 6'h00, 0, 3);       // lw, 3 wait cycles in MEM_READ (8 cycles)
      run_instr(6'h2B, 6'h00, 2, 0);       // sw, fetch stalls 2 cycles
      run_instr(6'h23, 6'h11, 10, 10);     // waits in separate states never sum up
      run_instr(6'h2B, 6'h00, 0, TMO - 1); // ready on the last allowed MEM_WRITE wait
      foreach (i_op[i]) run_instr(i_op[i], 6'h15, 0, 0);
      run_instr(6'h04, 6'h00, 0, 0);       // beq
      run_instr(6'h02, 6'h00, 0, 0);       // j
      run_instr(6'h03, 6'h00, 0, 0);       // jal
      run_instr(6'h00, 6'h08, 0, 0);       // jr
      run_instr(6'h00, 6'h20, TMO - 1, 0); // ready on the last allowed FETCH wait

      run_instr(6'h3F, 6'h00, 0, 0);       // undecodable opcode
      run_instr(6'h00, 6'h2A, 0, 0);       // undecodable R-type func
      reset_dut();

      // Fetch timeout: TMO cycles with no mem_ready -> HALT with bus_err
      op = 6'h00; func = 6'h20;
      repeat (TMO) cyc(P_FETCH, 1'b0);
      exp_bus_err = 1'b1;
      repeat (4) cyc(P_IDLE, 1'b1);        // HALT is absorbing even with mem_ready
      chk("ret_cnt_halt", 64'(ret_cnt), 64'(exp_ret));
      reset_dut();

      // MEM_READ timeout
      run_instr(6'h00, 6'h24, 0, 0);
      op = 6'h23;
      cyc(P_FETCH, 1'b1); cyc(P_DEC, 1'b0); cyc(P_MADDR, 1'b0);
      repeat (TMO) cyc(P_MRD, 1'b0);
      exp_bus_err = 1'b1;
      repeat (2) cyc(P_IDLE, 1'b1);
      chk("ret_cnt_halt2", 64'(ret_cnt), 64'(exp_ret));
      reset_dut();
      run_instr(6'h00, 6'h22, 0, 0);

      repeat (2) @(negedge clk);
      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
